// File: rtl/mad_io_controller_if.sv
// mad_io_controller_if: host and processor side signals
// of the I/O controller, grouped with directional modports.
interface mad_io_controller_if #(
  parameter int DEPTH = 4
);
  logic [15:0]            host_data;
  logic                   host_valid;
  logic                   host_ready;
  logic [15:0]            In_Port;
  logic                   in_read;
  logic                   Int;
  logic [15:0]            Out_Port;
  logic                   out_valid;
  logic [15:0]            tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic                   tx_overflow;
  logic [$clog2(DEPTH):0] rx_count;

  modport master (
    output host_data, host_valid, in_read,
    output Out_Port, out_valid, tx_ready,
    input  host_ready, In_Port, Int,
    input  tx_data, tx_valid, tx_overflow, rx_count
  );

  modport slave (
    input  host_data, host_valid, in_read,
    input  Out_Port, out_valid, tx_ready,
    output host_ready, In_Port, Int,
    output tx_data, tx_valid, tx_overflow, rx_count
  );
endinterface

// File: rtl/mad_io_controller.sv
// mad_io_controller: RX/TX word FIFOs between host and
// processor, with one interrupt pulse per received word.
module mad_io_controller #(
  parameter int DEPTH      = 4,
  parameter int INT_CYCLES = 1
) (
  input logic             Clk,
  input logic             Rst,
  mad_io_controller_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (INT_CYCLES > 1) ?
                      $clog2(INT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_WAIT
  } state_t;

  logic [15:0] r_rx_mem [DEPTH];
  logic [15:0] r_tx_mem [DEPTH];
  logic [AW:0] r_rx_wp;
  logic [AW:0] r_rx_rp;
  logic [AW:0] r_tx_wp;
  logic [AW:0] r_tx_rp;
  logic        r_tx_ovf;
  state_t      r_state;
  state_t      w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic        r_ack;
  logic        w_ack_nx;

  logic w_rx_empty;
  logic w_rx_full;
  logic w_rx_push;
  logic w_rx_pop;
  logic w_tx_empty;
  logic w_tx_full;
  logic w_tx_push;
  logic w_tx_pop;

  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) &&
    (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
  assign w_rx_push  = bus.host_valid && !w_rx_full;
  assign w_rx_pop   = bus.in_read && !w_rx_empty;

  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) &&
    (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
  assign w_tx_pop   = !w_tx_empty && bus.tx_ready;
  assign w_tx_push  = bus.out_valid &&
    (!w_tx_full || w_tx_pop);

  assign bus.host_ready  = !w_rx_full;
  assign bus.In_Port     = w_rx_empty ? 16'h0 :
    r_rx_mem[r_rx_rp[AW-1:0]];
  assign bus.rx_count    = r_rx_wp - r_rx_rp;
  assign bus.tx_valid    = !w_tx_empty;
  assign bus.tx_data     = w_tx_empty ? 16'h0 :
    r_tx_mem[r_tx_rp[AW-1:0]];
  assign bus.tx_overflow = r_tx_ovf;
  assign bus.Int         = (r_state == S_ASSERT);

  // Storage is never reset; empty masking hides stale words.
  always_ff @(posedge Clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= bus.host_data;
    if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= bus.Out_Port;
  end

  // FIFO pointers and the sticky drop flag.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_ovf <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (bus.out_valid && !w_tx_push) r_tx_ovf <= 1'b1;
    end
  end

  // Interrupt FSM state, pulse counter and ack flag.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_ack   <= w_ack_nx;
    end
  end

  // One pulse per word: a pop must be seen before re-arming.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_ack_nx   = r_ack;
    unique case (r_state)
      S_IDLE: begin
        if (!w_rx_empty) begin
          w_state_nx = S_ASSERT;
          w_cnt_nx   = CW'(INT_CYCLES - 1);
          w_ack_nx   = 1'b0;
        end
      end
      S_ASSERT: begin
        if (w_rx_pop) w_ack_nx = 1'b1;
        if (r_cnt == '0) begin
          w_state_nx = r_ack ? S_IDLE : S_WAIT;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      S_WAIT: begin
        if (w_rx_pop) w_ack_nx = 1'b1;
        if (w_rx_pop || r_ack) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_mad_io_controller.sv
// tb_mad_io_controller: directed vectors for the I/O
// controller with INT_CYCLES of 1 and of 3.
module tb_mad_io_controller;
  logic Clk;
  logic Rst;
  int   total;
  int   bad;
  int   pulses;
  int   base;
  logic r_prev;

  mad_io_controller_if #(.DEPTH(4)) b1 ();
  mad_io_controller_if #(.DEPTH(4)) b3 ();

  mad_io_controller #(.DEPTH(4), .INT_CYCLES(1)) u1 (
    .Clk(Clk), .Rst(Rst), .bus(b1)
  );
  mad_io_controller #(.DEPTH(4), .INT_CYCLES(3)) u3 (
    .Clk(Clk), .Rst(Rst), .bus(b3)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    pulses = 0;
    r_prev = 1'b0;
  end

  always @(posedge Clk) begin
    r_prev <= b1.Int;
    if (b1.Int === 1'b1 && r_prev !== 1'b1)
      pulses <= pulses + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_int();
    int n;
    n = 0;
    while (b1.Int !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("int_wait", 32'(b1.Int), 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Rst   = 1'b0;
    b1.host_data = '0; b1.host_valid = 0; b1.in_read = 0;
    b1.Out_Port  = '0; b1.out_valid  = 0; b1.tx_ready = 0;
    b3.host_data = '0; b3.host_valid = 0; b3.in_read = 0;
    b3.Out_Port  = '0; b3.out_valid  = 0; b3.tx_ready = 0;
    #1 Rst = 1'b1;
    #2;
    check("rst_int",   32'(b1.Int),         32'd0);
    check("rst_hrdy",  32'(b1.host_ready),  32'd1);
    check("rst_in",    32'(b1.In_Port),     32'd0);
    check("rst_txv",   32'(b1.tx_valid),    32'd0);
    check("rst_txd",   32'(b1.tx_data),     32'd0);
    check("rst_ovf",   32'(b1.tx_overflow), 32'd0);
    check("rst_cnt",   32'(b1.rx_count),    32'd0);
    @(negedge Clk) Rst = 1'b0;

    // reset mid-pulse
    b1.host_data = 16'h1234; b1.host_valid = 1;
    tick();
    b1.host_data = 16'h5678;
    tick();
    b1.host_valid = 0;
    check("mid_int",   32'(b1.Int),      32'd1);
    check("mid_cnt",   32'(b1.rx_count), 32'd2);
    #2 Rst = 1'b1;
    #1;
    check("arst_int",  32'(b1.Int),        32'd0);
    check("arst_in",   32'(b1.In_Port),    32'd0);
    check("arst_hrdy", 32'(b1.host_ready), 32'd1);
    @(negedge Clk) Rst = 1'b0;
    tick();
    check("arst_cnt",  32'(b1.rx_count), 32'd0);
    check("arst_int2", 32'(b1.Int),      32'd0);

    // single word, INT_CYCLES=1
    b1.host_data = 16'hA5A5; b1.host_valid = 1;
    tick();
    b1.host_valid = 0;
    check("sw_in",   32'(b1.In_Port),  32'h0000A5A5);
    check("sw_cnt",  32'(b1.rx_count), 32'd1);
    check("sw_int0", 32'(b1.Int),      32'd0);
    tick();
    check("sw_int1", 32'(b1.Int), 32'd1);
    tick();
    check("sw_int2", 32'(b1.Int), 32'd0);
    tick();
    check("sw_int3", 32'(b1.Int), 32'd0);
    b1.in_read = 1;
    tick();
    b1.in_read = 0;
    check("sw_rd_in",  32'(b1.In_Port),  32'd0);
    check("sw_rd_cnt", 32'(b1.rx_count), 32'd0);
    tick();
    check("sw_int4", 32'(b1.Int), 32'd0);
    tick();
    check("sw_int5", 32'(b1.Int), 32'd0);

    // RX fill and wrap
    base = pulses;
    b1.host_valid = 1;
    for (int v = 1; v <= 4; v++) begin
      b1.host_data = 16'(v);
      tick();
    end
    b1.host_data = 16'h0005;
    check("fill_cnt",  32'(b1.rx_count),   32'd4);
    check("fill_hrdy", 32'(b1.host_ready), 32'd0);
    tick();
    tick();
    check("fill_hrdy2", 32'(b1.host_ready), 32'd0);
    check("fill_cnt2",  32'(b1.rx_count),   32'd4);
    check("rd_1", 32'(b1.In_Port), 32'd1);
    b1.in_read = 1;
    tick();
    b1.in_read = 0;
    check("pop_hrdy", 32'(b1.host_ready), 32'd1);
    check("pop_cnt",  32'(b1.rx_count),   32'd3);
    check("pop_in",   32'(b1.In_Port),    32'd2);
    tick();
    b1.host_valid = 0;
    check("acc5_cnt", 32'(b1.rx_count), 32'd4);
    for (int v = 2; v <= 5; v++) begin
      wait_int();
      check($sformatf("rd_%0d", v), 32'(b1.In_Port), 32'(v));
      b1.in_read = 1;
      tick();
      b1.in_read = 0;
    end
    check("drain_in",  32'(b1.In_Port),  32'd0);
    check("drain_cnt", 32'(b1.rx_count), 32'd0);
    tick();
    tick();
    tick();
    check("pulses", 32'(pulses - base), 32'd5);
    b1.in_read = 1;
    tick();
    b1.in_read = 0;
    check("empty_cnt",  32'(b1.rx_count),   32'd0);
    check("empty_in",   32'(b1.In_Port),    32'd0);
    check("empty_hrdy", 32'(b1.host_ready), 32'd1);
    tick();
    check("empty_int",  32'(b1.Int), 32'd0);

    // early ack, INT_CYCLES=3
    b3.host_data = 16'hBEEF; b3.host_valid = 1;
    tick();
    b3.host_data = 16'hCAFE;
    tick();
    b3.host_valid = 0;
    check("ea_c1", 32'(b3.Int), 32'd1);
    tick();
    check("ea_c2", 32'(b3.Int), 32'd1);
    b3.in_read = 1;
    tick();
    b3.in_read = 0;
    check("ea_c3",  32'(b3.Int),      32'd1);
    check("ea_in",  32'(b3.In_Port),  32'h0000CAFE);
    check("ea_cnt", 32'(b3.rx_count), 32'd1);
    tick();
    check("ea_gap", 32'(b3.Int), 32'd0);
    tick();
    check("ea_p2a", 32'(b3.Int), 32'd1);
    tick();
    check("ea_p2b", 32'(b3.Int), 32'd1);
    tick();
    check("ea_p2c", 32'(b3.Int), 32'd1);
    tick();
    check("ea_end", 32'(b3.Int), 32'd0);
    tick();
    check("ea_wait", 32'(b3.Int), 32'd0);
    b3.in_read = 1;
    tick();
    b3.in_read = 0;
    check("ea_empty", 32'(b3.rx_count), 32'd0);

    // TX overflow
    b1.tx_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      b1.Out_Port  = 16'(i * 16'h1111);
      b1.out_valid = 1;
      tick();
      b1.out_valid = 0;
      if (i == 1) begin
        check("tx_v1", 32'(b1.tx_valid), 32'd1);
        check("tx_d1", 32'(b1.tx_data),  32'h00001111);
      end
      if (i == 4)
        check("ovf_4", 32'(b1.tx_overflow), 32'd0);
    end
    check("ovf_5", 32'(b1.tx_overflow), 32'd1);
    b1.tx_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("txd_%0d", i), 32'(b1.tx_data),
            32'(i * 16'h1111));
      check($sformatf("txv_%0d", i), 32'(b1.tx_valid), 32'd1);
      tick();
    end
    check("tx_empty_v", 32'(b1.tx_valid), 32'd0);
    check("tx_empty_d", 32'(b1.tx_data),  32'd0);
    b1.tx_ready = 0;

    // TX simultaneous push and pop when full
    #2 Rst = 1'b1;
    #1;
    check("rst_ovf2", 32'(b1.tx_overflow), 32'd0);
    @(negedge Clk) Rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      b1.Out_Port  = 16'(i * 16'h1111);
      b1.out_valid = 1;
      tick();
    end
    b1.Out_Port = 16'h7777;
    b1.tx_ready = 1;
    tick();
    b1.out_valid = 0;
    check("sim_ovf", 32'(b1.tx_overflow), 32'd0);
    check("sim_d",   32'(b1.tx_data),     32'h00002222);
    for (int i = 2; i <= 4; i++) begin
      check($sformatf("sim_d%0d", i), 32'(b1.tx_data),
            32'(i * 16'h1111));
      tick();
    end
    check("sim_last", 32'(b1.tx_data),  32'h00007777);
    tick();
    check("sim_done", 32'(b1.tx_valid), 32'd0);
    check("sim_ovf2", 32'(b1.tx_overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
